// File: rtl/lut_ram_if.sv
// rtl/lut_ram_if.sv - signal bundle for the lut_ram write/read ports
//
// Ports:
//   clk      - clock shared by the bundle
// Signals:
//   rst_n    - asynchronous active-low reset
//   wr_en    - write enable
//   wr_addr  - write word address
//   wr_data  - write data
//   rd_addr  - read word address
//   rd_data  - combinational read data
// Modports:
//   master   - drives reset, write and read address; receives rd_data
//   slave    - the memory side

interface lut_ram_intf #(
    parameter int LUT_WIDTH = 32,
    parameter int LUT_DEPTH = 256
) (
    input logic clk
);
    localparam int ADDR_WIDTH = $clog2(LUT_DEPTH);

    logic                  rst_n;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LUT_WIDTH-1:0]  wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [LUT_WIDTH-1:0]  rd_data;

    modport master (
        input  clk,
        output rst_n,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  clk,
        input  rst_n,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/lut_ram.sv
// rtl/lut_ram.sv - flop-based lookup RAM, synchronous write, asynchronous read
//
// Ports:
//   clk   - clock; writes land on its rising edge
//   rst_n - asynchronous active-low reset; clears every word while low
//   bus   - lut_ram_intf slave: wr_en/wr_addr/wr_data write port,
//           rd_addr in, rd_data out (combinational)

module lut_ram #(
    parameter int LUT_WIDTH = 32,
    parameter int LUT_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    lut_ram_intf.slave bus
);
    localparam int ADDR_WIDTH = $clog2(LUT_DEPTH);

    // Depth widened by one bit so it is representable even when LUT_DEPTH
    // is an exact power of two; addresses are zero-extended to compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(LUT_DEPTH);

    logic [LUT_WIDTH-1:0] mem_q [LUT_DEPTH];
    logic [LUT_WIDTH-1:0] mem_d [LUT_DEPTH];

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_EXT;

    // Out-of-range writes are dropped rather than wrapped, so a
    // non-power-of-two depth never aliases onto a low address.
    always_comb begin
        mem_d = mem_q;
        if (bus.wr_en && wr_in_range) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Reset wins over a coincident write edge: the negedge of rst_n
    // re-triggers this block and clears whatever the edge stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read straight from the storage flops: the old word is visible until
    // the write edge, the new one right after; no write-first bypass.
    always_comb begin
        bus.rd_data = '0;
        if (rd_in_range) begin
            bus.rd_data = mem_q[bus.rd_addr];
        end
    end
endmodule

// File: tb/tb_lut_ram.sv
// tb/tb_lut_ram.sv - self-checking bench for lut_ram (depth 256 and depth 200)

module tb_lut_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr;

    lut_ram_intf #(.LUT_WIDTH(32), .LUT_DEPTH(256)) if_a (.clk(clk));
    lut_ram_intf #(.LUT_WIDTH(32), .LUT_DEPTH(200)) if_b (.clk(clk));

    assign if_a.rst_n   = rst_n;
    assign if_a.wr_en   = wr_en;
    assign if_a.wr_addr = wr_addr;
    assign if_a.wr_data = wr_data;
    assign if_a.rd_addr = rd_addr;
    assign if_b.rst_n   = rst_n;
    assign if_b.wr_en   = wr_en;
    assign if_b.wr_addr = wr_addr;
    assign if_b.wr_data = wr_data;
    assign if_b.rd_addr = rd_addr;

    lut_ram #(.LUT_WIDTH(32), .LUT_DEPTH(256)) dut_a (
        .clk   (clk),
        .rst_n (if_a.rst_n),
        .bus   (if_a.slave)
    );

    lut_ram #(.LUT_WIDTH(32), .LUT_DEPTH(200)) dut_b (
        .clk   (clk),
        .rst_n (if_b.rst_n),
        .bus   (if_b.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference contents: plain arrays indexed by word address.
    logic [31:0] ref_a [256];
    logic [31:0] ref_b [200];

    function automatic logic [31:0] exp_a(input logic [7:0] a);
        return ref_a[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [7:0] a);
        if (int'(a) < 200) return ref_b[a];
        return 32'h0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) ref_a[i] = 32'h0;
        for (int i = 0; i < 200; i++) ref_b[i] = 32'h0;
    endtask

    // One write cycle on both memories; the model follows the write rules.
    task automatic do_write(input logic en, input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        if (en && rst_n) begin
            ref_a[addr] = data;
            if (int'(addr) < 200) ref_b[addr] = data;
        end
        #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        clear_model();
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            rd_addr = (k == 0) ? 8'd0 : (k == 1) ? 8'd1 : 8'd255;
            #1;
            checks++;
            if (if_a.rd_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_a addr=%0d got=%h exp=00000000", rd_addr, if_a.rd_data);
            end
            checks++;
            if (if_b.rd_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_b addr=%0d got=%h exp=00000000", rd_addr, if_b.rd_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(1'b1, 8'd0, 32'h1);
        @(posedge clk);
        #1;
        rd_addr = 8'd0;
        #1;
        checks++;
        if (if_a.rd_data !== 32'h1) begin
            errors++;
            $display("FAIL first_write got=%h exp=00000001", if_a.rd_data);
        end
        for (int i = 0; i < 10; i++) begin
            do_write((i % 2) == 0, 8'(i * 10), 32'(i + 1));
        end
        for (int a = 0; a < 256; a++) begin
            rd_addr = 8'(a);
            #1;
            checks++;
            if (if_a.rd_data !== exp_a(rd_addr)) begin
                errors++;
                $display("FAIL readback_a addr=%0d got=%h exp=%h", a, if_a.rd_data, exp_a(rd_addr));
            end
            checks++;
            if (if_b.rd_data !== exp_b(rd_addr)) begin
                errors++;
                $display("FAIL readback_b addr=%0d got=%h exp=%h", a, if_b.rd_data, exp_b(rd_addr));
            end
        end
    endtask

    task automatic test_read_during_write();
        do_write(1'b1, 8'd20, 32'hAAAA_AAAA);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 8'd20;
        wr_data = 32'h5555_5555;
        rd_addr = 8'd20;
        #1;
        checks++;
        if (if_a.rd_data !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL rdw_before got=%h exp=aaaaaaaa", if_a.rd_data);
        end
        @(posedge clk);
        ref_a[20] = 32'h5555_5555;
        ref_b[20] = 32'h5555_5555;
        #1;
        wr_en = 1'b0;
        checks++;
        if (if_a.rd_data !== 32'h5555_5555) begin
            errors++;
            $display("FAIL rdw_after got=%h exp=55555555", if_a.rd_data);
        end
        checks++;
        if (if_b.rd_data !== 32'h5555_5555) begin
            errors++;
            $display("FAIL rdw_after_b got=%h exp=55555555", if_b.rd_data);
        end
    endtask

    task automatic test_write_disable();
        do_write(1'b1, 8'd5, 32'h0BAD_F00D);
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = 8'd5;
        wr_data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        rd_addr = 8'd5;
        #1;
        checks++;
        if (if_a.rd_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL wr_en_low got=%h exp=0badf00d", if_a.rd_data);
        end
    endtask

    task automatic test_async_reset();
        do_write(1'b1, 8'd7, 32'h1234_5678);
        rd_addr = 8'd7;
        #1;
        checks++;
        if (if_a.rd_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL pre_reset got=%h exp=12345678", if_a.rd_data);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if (if_a.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL async_clear got=%h exp=00000000", if_a.rd_data);
        end
        // Writes are ignored while reset is held.
        do_write(1'b1, 8'd7, 32'hCAFE_0001);
        #1;
        checks++;
        if (if_a.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL write_in_reset got=%h exp=00000000", if_a.rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (if_a.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL after_release got=%h exp=00000000", if_a.rd_data);
        end
    endtask

    task automatic test_reset_collision();
        do_write(1'b1, 8'd3, 32'h0000_3333);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 8'd9;
        wr_data = 32'h9999_9999;
        rd_addr = 8'd9;
        @(posedge clk);
        rst_n = 1'b0;
        clear_model();
        #1;
        wr_en = 1'b0;
        checks++;
        if (if_a.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_wins got=%h exp=00000000", if_a.rd_data);
        end
        rd_addr = 8'd3;
        #1;
        checks++;
        if (if_a.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_discard got=%h exp=00000000", if_a.rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_write(1'b1, 8'd9, 32'h0F0F_0F0F);
        rd_addr = 8'd9;
        #1;
        checks++;
        if (if_a.rd_data !== exp_a(8'd9)) begin
            errors++;
            $display("FAIL first_after_reset got=%h exp=%h", if_a.rd_data, exp_a(8'd9));
        end
    endtask

    task automatic test_out_of_range();
        do_write(1'b1, 8'd20, 32'h1357_9BDF);
        do_write(1'b1, 8'd220, 32'hFFFF_FFFF);
        rd_addr = 8'd20;
        #1;
        checks++;
        if (if_b.rd_data !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL oor_no_alias got=%h exp=13579bdf", if_b.rd_data);
        end
        rd_addr = 8'd220;
        #1;
        checks++;
        if (if_b.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL oor_read got=%h exp=00000000", if_b.rd_data);
        end
        checks++;
        if (if_a.rd_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL in_range_220_a got=%h exp=ffffffff", if_a.rd_data);
        end
    endtask

    task automatic test_random();
        logic        en;
        logic [7:0]  a;
        logic [31:0] d;
        for (int n = 0; n < 300; n++) begin
            en = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            d  = $urandom;
            do_write(en, a, d);
            rd_addr = (n % 2 == 0) ? a : 8'($urandom_range(0, 255));
            #1;
            checks++;
            if (if_a.rd_data !== exp_a(rd_addr)) begin
                errors++;
                $display("FAIL random_a addr=%0d got=%h exp=%h", rd_addr, if_a.rd_data, exp_a(rd_addr));
            end
            checks++;
            if (if_b.rd_data !== exp_b(rd_addr)) begin
                errors++;
                $display("FAIL random_b addr=%0d got=%h exp=%h", rd_addr, if_b.rd_data, exp_b(rd_addr));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_during_write();
        test_write_disable();
        test_async_reset();
        test_reset_collision();
        test_out_of_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lut_ram.md
LUT_RAM -- requirements
Module: lut_ram

Interface
REQ-001 The block SHALL have parameter LUT_WIDTH, default 32 (XLEN), meaning the data word width in bits.
REQ-002 The block SHALL have parameter LUT_DEPTH, default 256, meaning the number of words; any value >= 2 is legal, including non-powers of two.
REQ-003 The block SHALL derive ADDR_WIDTH = $clog2(LUT_DEPTH) as a local parameter.
REQ-004 Port clk, input, 1 bit: the single clock; all writes occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port wr_en, input, 1 bit: write enable, sampled at the rising edge of clk.
REQ-007 Port wr_addr, input, ADDR_WIDTH bits: write word address.
REQ-008 Port wr_data, input, LUT_WIDTH bits: write data.
REQ-009 Port rd_addr, input, ADDR_WIDTH bits: read word address.
REQ-010 Port rd_data, output, LUT_WIDTH bits: read data.
REQ-011 The block SHALL be accompanied by interface lut_ram_intf, with parameters LUT_WIDTH and LUT_DEPTH and clk as its port, bundling rst_n, wr_en, wr_addr, wr_data, rd_addr and rd_data at identical widths.

Function
REQ-012 The block SHALL store LUT_DEPTH words of LUT_WIDTH bits each.
REQ-013 On the rising edge of clk with rst_n=1 and wr_en=1, the block SHALL write mem[wr_addr] <= wr_data.
REQ-014 When wr_en=0 at a rising edge, the block SHALL leave the memory unchanged.
REQ-015 The read SHALL be asynchronous (combinational): rd_data = mem[rd_addr] with zero-cycle latency, following rd_addr changes within the same cycle.
REQ-016 On read-during-write to the same address, rd_data SHALL show the old word until the write edge and the new word immediately after it; there is no write-first bypass.
REQ-017 A write whose wr_addr >= LUT_DEPTH SHALL be ignored, with no wrap-around and no aliasing.
REQ-018 A read whose rd_addr >= LUT_DEPTH SHALL return all zeros.
REQ-019 A write to address A SHALL leave every other address unchanged.
REQ-020 The block SHALL have no handshake: a write completes in 1 cycle and a read completes in 0 cycles.

Reset
REQ-021 While rst_n=0, every memory word SHALL be cleared to 0 asynchronously, and rd_data SHALL read 0 for any address.
REQ-022 While rst_n=0, writes SHALL be ignored, regardless of wr_en.
REQ-023 A write edge coincident with the assertion of rst_n SHALL lose the write; reset wins.
REQ-024 After rst_n deasserts, the first rising edge with wr_en=1 SHALL perform a normal write.
REQ-025 Reset asserted mid-operation SHALL discard all stored contents.

Verification (LUT_WIDTH=32, LUT_DEPTH=256)
REQ-026 Reset, then read addresses 0, 1 and 255 -> rd_data=0x00000000 for each.
REQ-027 Write 0x00000001 to address 0 (wr_en=1), then read address 0 one cycle later -> 0x00000001; repeat for i=0..9 with address i*10 and data i+1, alternating wr_en, then read back -> rd_data equals the last data written with wr_en=1 at each address, and 0 at addresses never written.
REQ-028 With mem[20]=0xAAAAAAAA, drive wr_en=1, wr_addr=20, wr_data=0x55555555, rd_addr=20 -> rd_data=0xAAAAAAAA before the edge and 0x55555555 from 1 ns after it.
REQ-029 With wr_en=0, drive wr_addr=5 and wr_data=0xDEADBEEF for 3 edges -> mem[5] is unchanged.
REQ-030 Write 0x12345678 to address 7, assert rst_n=0 between clock edges -> rd_data at rd_addr=7 becomes 0 immediately without waiting for a clock edge, and stays 0 after release.
REQ-031 With LUT_DEPTH=200, write 0xFFFFFFFF to address 220 -> the write is ignored, mem[220-200] is unchanged, and rd_addr=220 returns 0.
